via_shift_bridge: RTL and testbench
===================================

Name: via_shift_bridge

Overview:
Parametrised successor to the keyboard/ADB shift-clock engine in the Plus/SE data controller. It generates the VIA CB1 shift clock and moves DATA_W-bit frames serially between the VIA shift register (CB2) and a byte-parallel keyboard or ADB device model. Unlike the previous engine, it buffers device-to-Mac frames in a FIFO and supports runtime mode selection (Plus keyboard handshake or ADB). It adds a WAIT_RX timeout and FIFO overflow reporting. It sits in dataController_top between via6522 and ps2_kbd/adb.

Parameters:
DATA_W, 8, bits per serial frame, shifted MSB first
FIFO_DEPTH, 4, device-to-Mac frame buffer entries (power of 2, >=2)
DIV_PLUS, 1300, half-period of the shift clock in clk_en ticks minus 1, Plus mode
DIV_ADB, 127, half-period of the shift clock in clk_en ticks minus 1, ADB mode
WAIT_TIMEOUT, 65535, clk_en ticks allowed in WAIT_RX before abort (0 = never)

Ports:
clk32  in  1  system clock
_reset  in  1  synchronous active-low reset
clk_en  in  1  8 MHz enable (clk8_en_p)
mode  in  1  0 Plus keyboard, 1 ADB; sampled only in IDLE
cb2_o  in  1  VIA CB2 output value
cb2_t  in  1  VIA CB2 output enable; effective host data kbddat = ~cb2_t | cb2_o
cb1  out  1  shift clock to VIA
cb2_i  out  1  serial data to VIA
listen  in  1  ADB listen request; a rising edge starts TX in ADB mode
dev_din  in  DATA_W  frame from device to Mac
dev_din_strobe  in  1  push dev_din into FIFO (qualified by clk_en)
host_dout  out  DATA_W  frame received from Mac
host_dout_strobe  out  1  one clk_en tick pulse when host_dout is valid
busy  out  1  state != IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky; set on push when full; cleared by reset only

Behaviour:
- All state advances only on clk_en. Reset is synchronous: _reset low at a clk32 edge overrides clk_en.
- Reset values: cb1=1, cb2_i=1, host_dout=0, host_dout_strobe=0, busy=0, fifo_count=0, overflow=0, state=IDLE.
- State machine: IDLE, TX, WAIT_RX, RX. The mode is latched into mode_q on leaving IDLE.
- Divider runs only in TX and RX. Otherwise the counter is 0 and cb1=1. When the counter reaches DIV (DIV_PLUS or DIV_ADB per mode_q), cb1 toggles and the counter clears, giving a half-period of DIV+1 ticks.
- On a 1->0 toggle of cb1, TX shifts kbddat into the LSB of the shift register, and RX drives cb2_i with shreg[DATA_W-1-bitcnt].
- On a 0->1 toggle of cb1, bitcnt increments. The frame ends at bitcnt==DATA_W-1.
- IDLE->TX in Plus mode when kbddat==0. IDLE->TX in ADB mode on a listen rising edge, detected only while IDLE.
- IDLE->RX in ADB mode when the FIFO is non-empty. The head is popped into shreg.
- If TX and RX conditions are both true in the same tick, TX wins and the FIFO is untouched.
- End of TX: host_dout=shreg and host_dout_strobe pulses for 1 tick. Plus mode then goes to WAIT_RX; ADB mode goes to IDLE.
- WAIT_RX->RX when kbddat==1 and the FIFO is non-empty; the head is popped. If kbddat==1 and the FIFO is empty, stay in WAIT_RX.
- WAIT_RX timeout: after WAIT_TIMEOUT ticks (when nonzero), go to IDLE and leave the FIFO unchanged.
- End of RX: go to IDLE and set cb2_i=1.
- FIFO push when full: the data is dropped and overflow is set. A simultaneous push and pop when full succeeds, and fifo_count is unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- A mode change during a transfer has no effect until the next IDLE.
- Reset asserted mid-frame returns all outputs to reset values on the same edge and empties the FIFO.

Decomposition:
- Package via_shift_pkg holds the state enum (IDLE/TX/WAIT_RX/RX) and the MODE_PLUS=0/MODE_ADB=1 constants.
- One sub-module, sync_fifo (DATA_W, FIFO_DEPTH), provides push/pop/count/full/empty with synchronous active-low reset. The FSM and divider stay in the top.

Test Plan:
- Plus TX: mode=0; drive kbddat low, then shift 0xA5 MSB-first on cb1 falling edges. Expect host_dout=0xA5, one strobe, and state WAIT_RX. The cb1 half-period is 1301 ticks.
- Plus RX: push 0x3C, then release kbddat high in WAIT_RX. Expect cb2_i to carry bits 0,0,1,1,1,1,0,0 on successive cb1 falling edges, then IDLE with cb2_i=1 and fifo_count=0.
- ADB RX: mode=1; push 0x11 and 0x22. Expect two back-to-back RX frames with a half-period of 128 ticks, then fifo_count=0.
- Overflow: push 5 frames with FIFO_DEPTH=4 while in TX. Expect fifo_count=4 and overflow=1, and the 5th frame is absent on readback.
- Priority: mode=1; a listen edge and a non-empty FIFO arrive in the same tick. Expect TX first and fifo_count unchanged; RX follows after IDLE.
- Timeout and reset: with WAIT_TIMEOUT=100 and the FIFO empty in WAIT_RX, expect IDLE after 100 ticks. Assert _reset mid-RX: expect cb1=1, cb2_i=1, fifo_count=0, and overflow=0 on the next edge.

Source files
------------

// File: rtl/via_shift_pkg.sv
// Shared types for the VIA shift-clock bridge: FSM state encoding and mode constants.
package via_shift_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TX      = 2'd1,
      WAIT_RX = 2'd2,
      RX      = 2'd3
   } shiftStateT;

   localparam logic MODE_PLUS = 1'b0;
   localparam logic MODE_ADB  = 1'b1;

endpackage

// File: rtl/via_shift_bridge_sync_fifo.sv
// Device-to-Mac frame buffer: power-of-two depth, pointers wrap naturally.
module sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk32,
   input  logic                          _reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             pushData,
   output logic [DATA_W-1:0]             headData,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int PtrW = $clog2(FIFO_DEPTH);
   localparam int CntW = PtrW + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PtrW-1:0]   wrPtr;
   logic [PtrW-1:0]   rdPtr;
   logic              doPush;
   logic              doPop;

   assign full     = (count == CntW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign headData = mem[rdPtr];
   assign doPop    = pop & ~empty;
   // A push into a full buffer only lands when the head leaves on the same edge.
   assign doPush   = push & (~full | doPop);

   always_ff @(posedge clk32) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clk32) begin
      if (!_reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/via_shift_bridge.sv
// VIA CB1/CB2 shift-clock engine bridging Plus keyboard or ADB frames to a byte-parallel device,
// with a FIFO for device-to-Mac frames, a WAIT_RX timeout and sticky overflow reporting.
module via_shift_bridge
   import via_shift_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int DIV_PLUS     = 1300,
   parameter int DIV_ADB      = 127,
   parameter int WAIT_TIMEOUT = 65535
) (
   input  logic                          clk32,
   input  logic                          _reset,
   input  logic                          clk_en,
   input  logic                          mode,
   input  logic                          cb2_o,
   input  logic                          cb2_t,
   output logic                          cb1,
   output logic                          cb2_i,
   input  logic                          listen,
   input  logic [DATA_W-1:0]             dev_din,
   input  logic                          dev_din_strobe,
   output logic [DATA_W-1:0]             host_dout,
   output logic                          host_dout_strobe,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [1:0]                    dbgState
);

   localparam int DivMax = (DIV_PLUS > DIV_ADB) ? DIV_PLUS : DIV_ADB;
   localparam int DivW   = (DivMax < 1) ? 1 : $clog2(DivMax + 1);
   localparam int WaitW  = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
   localparam int BitW   = $clog2(DATA_W);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

   shiftStateT        state;
   logic              modeQ;
   logic              listenQ;
   logic [DivW-1:0]   divCnt;
   logic [DivW-1:0]   divSel;
   logic [BitW-1:0]   bitCnt;
   logic [WaitW-1:0]  waitCnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] fifoHead;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              kbdDat;
   logic              listenRise;
   logic              txStart;
   logic              popReq;

   assign kbdDat     = ~cb2_t | cb2_o;
   assign listenRise = listen & ~listenQ;
   assign txStart    = (mode == MODE_ADB) ? listenRise : ~kbdDat;
   assign divSel     = (modeQ == MODE_ADB) ? DivW'(DIV_ADB) : DivW'(DIV_PLUS);
   assign busy       = (state != IDLE);
   assign dbgState   = state;

   // Pops happen only on the tick the FSM commits to RX; a listen edge in IDLE wins over a pending frame.
   always_comb begin
      popReq = 1'b0;
      if (state == IDLE)
         popReq = (mode == MODE_ADB) && !listenRise && !fifoEmpty;
      else if (state == WAIT_RX)
         popReq = kbdDat && !fifoEmpty;
   end

   // dev_din_strobe is a fire-and-forget push: no ready, full pushes drop and raise overflow.
   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk32    (clk32),
      ._reset   (_reset),
      .push     (clk_en & dev_din_strobe),
      .pop      (clk_en & popReq),
      .pushData (dev_din),
      .headData (fifoHead),
      .count    (fifo_count),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   always_ff @(posedge clk32) begin
      if (!_reset) begin
         state            <= IDLE;
         modeQ            <= MODE_PLUS;
         listenQ          <= 1'b0;
         divCnt           <= '0;
         bitCnt           <= '0;
         waitCnt          <= '0;
         shreg            <= '0;
         cb1              <= 1'b1;
         cb2_i            <= 1'b1;
         host_dout        <= '0;
         host_dout_strobe <= 1'b0;
         overflow         <= 1'b0;
      end else if (clk_en) begin
         listenQ          <= listen;
         host_dout_strobe <= 1'b0;
         if (dev_din_strobe && fifoFull && !popReq) overflow <= 1'b1;

         case (state)
            IDLE: begin
               divCnt  <= '0;
               bitCnt  <= '0;
               waitCnt <= '0;
               cb1     <= 1'b1;
               if (txStart) begin
                  state <= TX;
                  modeQ <= mode;
               end else if (popReq) begin
                  state <= RX;
                  modeQ <= mode;
                  shreg <= fifoHead;
               end
            end

            TX, RX: begin
               if (divCnt == divSel) begin
                  divCnt <= '0;
                  cb1    <= ~cb1;
                  if (cb1) begin
                     if (state == TX) shreg <= {shreg[DATA_W-2:0], kbdDat};
                     else             cb2_i <= shreg[LastBit - bitCnt];
                  end else if (bitCnt == LastBit) begin
                     bitCnt <= '0;
                     if (state == TX) begin
                        host_dout        <= shreg;
                        host_dout_strobe <= 1'b1;
                        state            <= (modeQ == MODE_PLUS) ? WAIT_RX : IDLE;
                     end else begin
                        cb2_i <= 1'b1;
                        state <= IDLE;
                     end
                  end else begin
                     bitCnt <= bitCnt + 1'b1;
                  end
               end else begin
                  divCnt <= divCnt + 1'b1;
               end
            end

            WAIT_RX: begin
               if (popReq) begin
                  state   <= RX;
                  shreg   <= fifoHead;
                  waitCnt <= '0;
               end else if (WAIT_TIMEOUT != 0 && waitCnt == WaitW'(WAIT_TIMEOUT - 1)) begin
                  state   <= IDLE;
                  waitCnt <= '0;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_via_shift_bridge.sv
// Directed bench for via_shift_bridge: Plus and ADB transfers, FIFO overflow, priority, timeout, reset.
module tb_via_shift_bridge;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_TX   = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RX   = 2'd3;

   typedef struct {
      logic [7:0] txByte;
      logic [7:0] expDout;
      logic [1:0] expStart;
      logic [1:0] expEnd;
      int         expHalf;
   } adbVecT;

   logic       clk32 = 1'b0;
   logic       _reset;
   logic       clk_en;
   logic       mode;
   logic       cb2_o;
   logic       cb2_t;
   logic       cb1;
   logic       cb2_i;
   logic       listen;
   logic [7:0] dev_din;
   logic       dev_din_strobe;
   logic [7:0] host_dout;
   logic       host_dout_strobe;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;
   logic [1:0] dbgState;

   int         nTests = 0;
   int         nFail = 0;
   int         cyc = 0;
   int         strobeCnt = 0;
   logic       hung = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk32 = ~clk32;

   always @(posedge clk32) cyc <= cyc + 1;

   always @(negedge clk32) begin
      if (host_dout_strobe === 1'b1) strobeCnt <= strobeCnt + 1;
   end

   initial begin
      repeat (200000) @(posedge clk32);
      $display("FAIL watchdog: run did not finish in 200000 cycles");
      $fatal(1, "watchdog");
   end

   via_shift_bridge #(
      .DATA_W       (8),
      .FIFO_DEPTH   (4),
      .DIV_PLUS     (1300),
      .DIV_ADB      (127),
      .WAIT_TIMEOUT (100)
   ) dut (
      .clk32            (clk32),
      ._reset           (_reset),
      .clk_en           (clk_en),
      .mode             (mode),
      .cb2_o            (cb2_o),
      .cb2_t            (cb2_t),
      .cb1              (cb1),
      .cb2_i            (cb2_i),
      .listen           (listen),
      .dev_din          (dev_din),
      .dev_din_strobe   (dev_din_strobe),
      .host_dout        (host_dout),
      .host_dout_strobe (host_dout_strobe),
      .busy             (busy),
      .fifo_count       (fifo_count),
      .overflow         (overflow),
      .dbgState         (dbgState)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk32);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitCb1(input logic v);
      int n;
      n = 0;
      if (hung) return;
      while (cb1 !== v && n < 3000) begin
         @(negedge clk32);
         n++;
      end
      if (cb1 !== v) begin
         hung = 1'b1;
         nTests++;
         nFail++;
         $display("FAIL cb1_wait: cb1=%b, want %b within 3000 cycles", cb1, v);
      end
   endtask

   // Host side of a Mac-to-device frame: present each bit before the cb1 falling edge that samples it.
   task automatic sendFrame(input logic [7:0] b, output int half);
      int tFall;
      half  = 0;
      tFall = 0;
      for (int i = 7; i >= 0; i--) begin
         cb2_t = 1'b1;
         cb2_o = b[i];
         waitCb1(1'b0);
         if (i == 7) tFall = cyc;
         waitCb1(1'b1);
         if (i == 7) half = cyc - tFall;
      end
   endtask

   task automatic recvFrame(output logic [7:0] b, output int half);
      int tFall;
      half  = 0;
      tFall = 0;
      b     = '0;
      for (int i = 7; i >= 0; i--) begin
         waitCb1(1'b0);
         if (i == 7) tFall = cyc;
         b[i] = cb2_i;
         waitCb1(1'b1);
         if (i == 7) half = cyc - tFall;
      end
   endtask

   task automatic pushDev(input logic [7:0] b);
      dev_din        = b;
      dev_din_strobe = 1'b1;
      tick(1);
      dev_din_strobe = 1'b0;
      if (exp_q.size() < 4) exp_q.push_back(b);
   endtask

   initial begin
      adbVecT     vecs[2];
      logic [7:0] ovfVals[5];
      logic [7:0] rxB;
      logic [7:0] expB;
      int         half;
      int         s0;

      vecs[0] = '{8'hC3, 8'hC3, S_TX, S_IDLE, 128};
      vecs[1] = '{8'h7E, 8'h7E, S_TX, S_IDLE, 128};
      ovfVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      _reset = 1'b0; clk_en = 1'b1; mode = 1'b0; cb2_o = 1'b0; cb2_t = 1'b0;
      listen = 1'b0; dev_din = '0; dev_din_strobe = 1'b0;
      tick(3);
      check("rst_cb1", cb1, 1);
      check("rst_cb2_i", cb2_i, 1);
      check("rst_host_dout", host_dout, 0);
      check("rst_strobe", host_dout_strobe, 0);
      check("rst_busy", busy, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_state", dbgState, S_IDLE);
      _reset = 1'b1;
      tick(2);

      // Plus TX of 0xA5; kbddat held low while clk_en is off must not start a transfer.
      clk_en = 1'b0; cb2_t = 1'b1; cb2_o = 1'b0;
      tick(4);
      check("clk_en_gate", busy, 0);
      clk_en = 1'b1;
      s0 = strobeCnt;
      tick(1);
      check("plus_tx_start", dbgState, S_TX);
      sendFrame(8'hA5, half);
      check("plus_tx_dout", host_dout, 8'hA5);
      check("plus_tx_state", dbgState, S_WAIT);
      check("plus_half", half, 1301);
      tick(2);
      check("plus_strobe_once", strobeCnt - s0, 1);
      check("plus_wait_empty", dbgState, S_WAIT);

      // Plus RX of 0x3C after the host releases the data line.
      cb2_o = 1'b0;
      pushDev(8'h3C);
      check("plus_push_count", fifo_count, 1);
      check("plus_wait_held", dbgState, S_WAIT);
      cb2_t = 1'b0;
      tick(1);
      check("plus_rx_start", dbgState, S_RX);
      check("plus_rx_popped", fifo_count, 0);
      recvFrame(rxB, half);
      expB = exp_q.pop_front();
      check("plus_rx_data", rxB, expB);
      check("plus_rx_half", half, 1301);
      check("plus_rx_end_state", dbgState, S_IDLE);
      check("plus_rx_end_cb2_i", cb2_i, 1);
      check("plus_rx_end_count", fifo_count, 0);

      // WAIT_RX timeout with an empty FIFO.
      cb2_t = 1'b1; cb2_o = 1'b0;
      tick(1);
      check("plus_tx2_start", dbgState, S_TX);
      sendFrame(8'h5A, half);
      check("plus_tx2_dout", host_dout, 8'h5A);
      cb2_t = 1'b0;
      tick(99);
      check("timeout_not_yet", dbgState, S_WAIT);
      tick(1);
      check("timeout_idle", dbgState, S_IDLE);
      check("timeout_fifo", fifo_count, 0);

      // ADB TX vectors started by listen edges.
      mode = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s0 = strobeCnt;
         listen = 1'b1;
         tick(1);
         listen = 1'b0;
         check("adb_tx_start", dbgState, vecs[i].expStart);
         sendFrame(vecs[i].txByte, half);
         check("adb_tx_dout", host_dout, vecs[i].expDout);
         check("adb_tx_end", dbgState, vecs[i].expEnd);
         check("adb_tx_half", half, vecs[i].expHalf);
         tick(2);
         check("adb_strobe_once", strobeCnt - s0, 1);
         cb2_t = 1'b0;
      end

      // Overflow: five pushes into a four-entry FIFO while TX holds off popping.
      listen = 1'b1;
      tick(1);
      listen = 1'b0;
      check("ovf_tx_start", dbgState, S_TX);
      for (int i = 0; i < 5; i++) begin
         pushDev(ovfVals[i]);
         if (i == 3) begin
            check("ovf_full_count", fifo_count, 4);
            check("ovf_not_yet", overflow, 0);
         end
      end
      check("ovf_count", fifo_count, 4);
      check("ovf_flag", overflow, 1);
      sendFrame(8'h96, half);
      check("ovf_tx_dout", host_dout, 8'h96);
      cb2_t = 1'b0;
      for (int k = 0; k < 4; k++) begin
         recvFrame(rxB, half);
         expB = exp_q.pop_front();
         check("ovf_readback", rxB, expB);
         if (k == 0) check("adb_rx_half", half, 128);
      end
      tick(3);
      check("ovf_drained_busy", busy, 0);
      check("ovf_drained_count", fifo_count, 0);

      // Listen edge and non-empty FIFO on the same tick: TX goes first.
      pushDev(8'h5C);
      listen = 1'b1;
      tick(1);
      listen = 1'b0;
      check("prio_tx_first", dbgState, S_TX);
      check("prio_fifo_kept", fifo_count, 1);
      sendFrame(8'hE7, half);
      check("prio_tx_dout", host_dout, 8'hE7);
      check("prio_fifo_after_tx", fifo_count, 1);
      cb2_t = 1'b0;
      recvFrame(rxB, half);
      expB = exp_q.pop_front();
      check("prio_rx_data", rxB, expB);
      check("prio_rx_count", fifo_count, 0);

      // Reset in the middle of an RX frame.
      pushDev(8'hA1);
      pushDev(8'hB2);
      check("mid_rx_start", dbgState, S_RX);
      check("mid_rx_count", fifo_count, 1);
      waitCb1(1'b0);
      waitCb1(1'b1);
      waitCb1(1'b0);
      check("mid_rx_cb1", cb1, 0);
      check("mid_rx_cb2_i", cb2_i, 0);
      check("mid_rx_overflow", overflow, 1);
      _reset = 1'b0;
      tick(1);
      check("mid_rst_cb1", cb1, 1);
      check("mid_rst_cb2_i", cb2_i, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_host_dout", host_dout, 0);
      _reset = 1'b1;
      exp_q.delete();
      tick(5);
      check("post_rst_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
